// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end and its RAM-facing neighbours.
// Frame layout: [9:8] command, [7:0] address or data.
package spi_pkg;

    localparam int SPI_FRAME_W = 10;
    localparam int SPI_DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_piso.sv
// Parallel-load / serial-out shifter that drives MISO, MSB first.
// The output is forced low whenever no bits remain, so an idle or aborted shifter reads as 0.
module spi_shift_piso
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic              abort,
    input  logic [DATA_W-1:0] din,
    output logic              sout
);

    localparam int BCNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh_q;
    logic [BCNT_W-1:0] left_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            left_q <= '0;
        end else if (abort) begin
            sh_q   <= '0;
            left_q <= '0;
        end else if (load) begin
            sh_q   <= din;
            left_q <= BCNT_W'(DATA_W);
        end else if (shift_en && (left_q != '0)) begin
            sh_q   <= {sh_q[DATA_W-2:0], 1'b0};
            left_q <= left_q - 1'b1;
        end
    end

    // The current MSB is on the wire for the whole cycle it is counted as pending.
    assign sout = (left_q != '0) & sh_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises MOSI into command/data words for the RAM stage
// and serialises the RAM's read data back onto MISO.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = SPI_FRAME_W,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int CNT_W = $clog2(FRAME_W + DATA_W);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] shift_q;
    logic               rd_addr_seen;
    logic               in_frame_state;
    logic               rx_phase;
    logic               frame_done;
    logic               tx_wait;
    logic               tx_load;

    assign in_frame_state = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
    assign rx_phase       = in_frame_state && (cnt_q < CNT_W'(FRAME_W));
    // A deselect on the cycle of the last bit wins over completion.
    assign frame_done     = rx_phase && !SS_n && (cnt_q == CNT_W'(FRAME_W - 1));
    // After the strobe of a read-data frame the counter parks at FRAME_W until the RAM answers;
    // bumping it past FRAME_W on the load makes further tx_valid pulses inert.
    assign tx_wait        = (state_q == READ_DATA) && (cnt_q == CNT_W'(FRAME_W));
    assign tx_load        = tx_wait && !SS_n && tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)              state_d = IDLE;
                else if (!MOSI)        state_d = WRITE;
                else if (rd_addr_seen) state_d = READ_DATA;
                else                   state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n || !in_frame_state) begin
                cnt_q   <= '0;
                shift_q <= '0;
            end else if (rx_phase) begin
                shift_q <= {shift_q[FRAME_W-2:0], MOSI};
                cnt_q   <= cnt_q + 1'b1;
                if (frame_done) begin
                    rx_data  <= {shift_q[FRAME_W-2:0], MOSI};
                    rx_valid <= 1'b1;
                    if (state_q == READ_ADD)       rd_addr_seen <= 1'b1;
                    else if (state_q == READ_DATA) rd_addr_seen <= 1'b0;
                end
            end else if (tx_load) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    spi_shift_piso #(
        .DATA_W (DATA_W)
    ) u_miso_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .shift_en (state_q == READ_DATA),
        .abort    (SS_n),
        .din      (tx_data),
        .sout     (MISO)
    );

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write/read frames, MISO shift-out, aborts, async reset.
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int total = 0;
    int bad   = 0;

    spi_slave_if dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic path);
        SS_n = 1'b0;
        @(negedge clk);
        MOSI = path;
        @(negedge clk);
    endtask

    // Full frame; leaves SS_n low one cycle after the strobe.
    task automatic run_frame(input string tag, input logic path, input logic [9:0] w);
        start_frame(path);
        for (int i = 9; i >= 0; i--) begin
            check({tag, "_nostrobe"}, 32'(rx_valid), 32'd0);
            check({tag, "_miso_idle"}, 32'(MISO), 32'd0);
            MOSI = w[i];
            @(negedge clk);
        end
        check({tag, "_strobe"}, 32'(rx_valid), 32'd1);
        check({tag, "_data"}, 32'(rx_data), 32'(w));
        MOSI = 1'b0;
        @(negedge clk);
        check({tag, "_strobe_once"}, 32'(rx_valid), 32'd0);
        check({tag, "_data_hold"}, 32'(rx_data), 32'(w));
    endtask

    task automatic end_frame;
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        check("deselect_idle", 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        logic [7:0] rd_byte;
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_rd_seen", 32'(dut.rd_addr_seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("wr_addr", 1'b0, 10'h0A5);
        end_frame();

        run_frame("wr_data", 1'b0, 10'h13C);
        check("wr_data_rd_seen", 32'(dut.rd_addr_seen), 32'd0);
        end_frame();

        run_frame("rd_addr", 1'b1, 10'h207);
        check("rd_addr_rd_seen", 32'(dut.rd_addr_seen), 32'd1);
        end_frame();
        check("rd_seen_kept", 32'(dut.rd_addr_seen), 32'd1);

        SS_n = 1'b0;
        @(negedge clk);
        MOSI = 1'b1;
        @(negedge clk);
        check("rd_data_state", 32'(dut.state_q), 32'(READ_DATA));
        for (int i = 9; i >= 0; i--) begin
            MOSI = (10'h300 >> i) & 10'h1;
            @(negedge clk);
        end
        check("rd_data_strobe", 32'(rx_valid), 32'd1);
        check("rd_data_data", 32'(rx_data), 32'h300);
        MOSI = 1'b0;
        @(negedge clk);
        check("rd_data_rd_seen", 32'(dut.rd_addr_seen), 32'd0);
        check("wait_tx_miso", 32'(MISO), 32'd0);
        @(negedge clk);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        rd_byte  = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            check($sformatf("miso_c3_bit%0d", i), 32'(MISO), 32'(rd_byte[i]));
            if (i == 5) begin
                tx_data  = 8'h00;
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("miso_after_0", 32'(MISO), 32'd0);
        @(negedge clk);
        check("miso_after_1", 32'(MISO), 32'd0);
        end_frame();

        start_frame(1'b0);
        for (int i = 9; i >= 2; i--) begin
            MOSI = 1'b1;
            @(negedge clk);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        check("abort_state", 32'(dut.state_q), 32'(IDLE));
        check("abort_nostrobe", 32'(rx_valid), 32'd0);
        @(negedge clk);
        check("abort_nostrobe2", 32'(rx_valid), 32'd0);
        check("abort_data_kept", 32'(rx_data), 32'h300);

        start_frame(1'b0);
        for (int i = 9; i >= 1; i--) begin
            MOSI = 1'b0;
            @(negedge clk);
        end
        SS_n = 1'b1;
        @(negedge clk);
        check("late_abort_nostrobe", 32'(rx_valid), 32'd0);
        @(negedge clk);
        check("late_abort_data_kept", 32'(rx_data), 32'h300);

        run_frame("rd_addr2", 1'b1, 10'h2AA);
        end_frame();
        run_frame("rd_data2", 1'b1, 10'h3AA);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ff_bit_high", 32'(MISO), 32'd1);
            @(negedge clk);
        end
        #2;
        check("pre_reset_miso", 32'(MISO), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_miso", 32'(MISO), 32'd0);
        check("async_rst_valid", 32'(rx_valid), 32'd0);
        check("async_rst_state", 32'(dut.state_q), 32'(IDLE));
        check("async_rst_rd_seen", 32'(dut.rd_addr_seen), 32'd0);
        check("async_rst_rx_data", 32'(rx_data), 32'd0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("b2b_a", 1'b0, 10'h0FF);
        end_frame();
        run_frame("b2b_b", 1'b0, 10'h155);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
